// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-and-add unsigned multiplier: one add/shift step per clock,
// start/ready handshake, registered product with a one-cycle done pulse.
module shift_add_mult_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic                 shift_load,
   output logic                 shift_stop
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   logic [2*WIDTH-1:0]   p;
   logic [WIDTH-1:0]     mcand;
   logic [CW-1:0]        count;
   logic [2*WIDTH-1:0]   p_step;

   // The accumulator add keeps its carry; it re-enters at the MSB on the shift.
   function automatic logic [2*WIDTH-1:0] add_shift(input logic [2*WIDTH-1:0] pv,
                                                    input logic [WIDTH-1:0]   mv);
      logic [WIDTH:0] sum;
      sum = {1'b0, pv[2*WIDTH-1:WIDTH]} + (pv[0] ? {1'b0, mv} : {(WIDTH+1){1'b0}});
      return {sum, pv[WIDTH-1:1]};
   endfunction

   assign p_step     = add_shift(p, mcand);
   assign ready      = (state == IDLE);
   assign busy       = (state == RUN) || (state == DONE);
   assign shift_stop = (state != RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         p          <= '0;
         mcand      <= '0;
         count      <= '0;
         product    <= '0;
         done       <= 1'b0;
         shift_load <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  p          <= {{WIDTH{1'b0}}, multiplier};
                  mcand      <= multiplicand;
                  count      <= '0;
                  shift_load <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               p          <= p_step;
               count      <= count + 1'b1;
               shift_load <= 1'b0;
               if (count == LAST) begin
                  product <= p_step;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done       <= 1'b0;
               shift_load <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: vector table, start/reset corner sequences,
// and random operands against A*B on 8-bit and 4-bit builds.
module tb_shift_add_mult_ctrl;

   localparam int W  = 8;
   localparam int W4 = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic            start = 1'b0;
   logic [W-1:0]    mcand_in = '0, mplier_in = '0;
   logic            ready, busy, done, shift_load, shift_stop;
   logic [2*W-1:0]  product;

   logic            start4 = 1'b0;
   logic [W4-1:0]   mcand4 = '0, mplier4 = '0;
   logic            ready4, busy4, done4, shift_load4, shift_stop4;
   logic [2*W4-1:0] product4;

   int errors = 0;
   int checks = 0;

   shift_add_mult_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .multiplicand(mcand_in), .multiplier(mplier_in),
      .ready(ready), .busy(busy), .done(done), .product(product),
      .shift_load(shift_load), .shift_stop(shift_stop)
   );

   shift_add_mult_ctrl #(.WIDTH(W4)) dut4 (
      .clk(clk), .rst(rst), .start(start4),
      .multiplicand(mcand4), .multiplier(mplier4),
      .ready(ready4), .busy(busy4), .done(done4), .product(product4),
      .shift_load(shift_load4), .shift_stop(shift_stop4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // done must never stay high two cycles; product may move only with done or reset
   logic            done_prev = 1'b0;
   logic            rst_q     = 1'b1;
   logic [2*W-1:0]  prod_prev;
   always @(posedge clk) rst_q <= rst;
   always @(negedge clk) begin
      if (done) begin
         checks++;
         if (done_prev) begin
            errors++;
            $display("FAIL done_twice: got done high on consecutive cycles expected single pulse");
         end
      end
      if (product !== prod_prev) begin
         checks++;
         if (!done && !rst_q) begin
            errors++;
            $display("FAIL product_hold: got %0h expected %0h", product, prod_prev);
         end
      end
      done_prev <= done;
      prod_prev <= product;
   end

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("wait_ready", {31'd0, ready}, 32'd1);
   endtask

   task automatic run8(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp);
      int n = 0;
      bit got = 0;
      wait_ready();
      mcand_in = a; mplier_in = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("accept_ready", {31'd0, ready}, 32'd0);
      chk("accept_busy", {31'd0, busy}, 32'd1);
      chk("accept_load", {31'd0, shift_load}, 32'd1);
      chk("accept_stop", {31'd0, shift_stop}, 32'd0);
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk); #1;
         n++;
         if (done) got = 1;
      end
      chk("latency", n, W);
      chk("product", product, exp);
      chk("done_busy", {29'd0, busy, ready, shift_stop}, 32'b101);
      @(posedge clk); #1;
      chk("after_done", {30'd0, ready, done}, 32'b10);
   endtask

   task automatic run4(input logic [W4-1:0] a, input logic [W4-1:0] b, input logic [2*W4-1:0] exp);
      int n = 0;
      bit got = 0;
      mcand4 = a; mplier4 = b; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      chk("w4_accept", {29'd0, ready4, busy4, shift_stop4}, 32'b010);
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk); #1;
         n++;
         if (done4) got = 1;
      end
      chk("w4_latency", n, W4);
      chk("w4_product", product4, exp);
      @(posedge clk); #1;
      chk("w4_idle", {30'd0, ready4, done4}, 32'b10);
   endtask

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] p;
   } vec_t;
   vec_t vecs[8];

   initial begin
      int last, loads, dones;
      logic [W-1:0] ra, rb;
      logic [W4-1:0] qa, qb;

      vecs[0] = '{8'h0D, 8'h0B, 16'h008F};
      vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
      vecs[2] = '{8'h00, 8'h5A, 16'h0000};
      vecs[3] = '{8'h12, 8'h34, 16'h03A8};
      vecs[4] = '{8'h03, 8'h05, 16'h000F};
      vecs[5] = '{8'h01, 8'hFF, 16'h00FF};
      vecs[6] = '{8'h80, 8'h02, 16'h0100};
      vecs[7] = '{8'hFF, 8'h00, 16'h0000};

      // reset state
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_ctrl", {27'd0, ready, busy, done, shift_load, shift_stop}, 32'b10001);
      chk("rst_product", product, 0);
      chk("rst_w4", {29'd0, ready4, done4, shift_stop4}, 32'b101);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run8(vecs[i].a, vecs[i].b, vecs[i].p);

      // start pulses during RUN and DONE are ignored
      wait_ready();
      mcand_in = 8'h0D; mplier_in = 8'h0B; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dones = 0;
      for (int k = 1; k <= W + 3; k++) begin
         if (k == 3 || k == 7 || k == W + 1) begin
            start = 1'b1; mcand_in = 8'h55; mplier_in = 8'h66;
         end
         @(posedge clk); #1;
         start = 1'b0;
         chk("ignore_load", {31'd0, shift_load}, 32'd0);
         if (done) begin
            dones++;
            chk("ignore_product", product, 16'h008F);
         end
      end
      chk("ignore_dones", dones, 1);
      chk("ignore_ready", {31'd0, ready}, 32'd1);

      // start held high: one accept every W+2 clocks
      wait_ready();
      mcand_in = 8'h12; mplier_in = 8'h34; start = 1'b1;
      last = -1; loads = 0; dones = 0;
      for (int cyc = 0; cyc < 50; cyc++) begin
         @(posedge clk); #1;
         if (shift_load) begin
            loads++;
            if (last >= 0) chk("held_period", cyc - last, W + 2);
            last = cyc;
         end
         if (done) begin
            dones++;
            chk("held_product", product, 16'h03A8);
         end
      end
      start = 1'b0;
      chk("held_loads", loads, 5);
      chk("held_dones", dones, 5);

      // reset in the middle of a run
      wait_ready();
      mcand_in = 8'h0D; mplier_in = 8'h0B; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_ctrl", {27'd0, ready, busy, done, shift_load, shift_stop}, 32'b10001);
      chk("midrst_product", product, 0);
      run8(8'h03, 8'h05, 16'h000F);

      for (int i = 0; i < 150; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         run8(ra, rb, 16'(ra) * 16'(rb));
      end

      run4(4'hF, 4'hF, 8'hE1);
      for (int i = 0; i < 1000; i++) begin
         qa = 4'($urandom_range(0, 15));
         qb = 4'($urandom_range(0, 15));
         run4(qa, qb, 8'(qa) * 8'(qb));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
